// File: rtl/column_l1route_pipe.sv
// column_l1route_pipe: two-stage valid/ready router that circularly rotates each stride unit's lanes
// by its own shift factor and direction, flagging out-of-range shifts per stride.
module column_l1route_pipe #(
   parameter int QUAN_SIZE        = 4,
   parameter int STRIDE_UNIT_SIZE = 15,
   parameter int STRIDE_WIDTH     = 3,
   parameter int SHIFT_W          = $clog2(STRIDE_UNIT_SIZE),
   parameter int MSG_W            = STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE
) (
   input  logic                            sys_clk,
   input  logic                            rstn,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [MSG_W-1:0]                in_msg,
   input  logic [STRIDE_WIDTH*SHIFT_W-1:0] in_shift,
   input  logic [STRIDE_WIDTH-1:0]         in_dir,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [MSG_W-1:0]                out_msg,
   output logic [STRIDE_WIDTH-1:0]         out_shift_err,
   output logic                            err_sticky,
   input  logic                            err_clr,
   output logic [15:0]                     beat_cnt
);
   localparam int N = STRIDE_UNIT_SIZE;
   localparam int Q = QUAN_SIZE;
   localparam int S = STRIDE_WIDTH;

   logic                 r_s1_valid, r_s2_valid, r_sticky;
   logic [MSG_W-1:0]     r_s1_msg, r_s2_msg, w_rot;
   logic [S*SHIFT_W-1:0] r_s1_shift;
   logic [S-1:0]         r_s1_dir, r_s2_err, w_err;
   logic [15:0]          r_cnt;
   logic                 w_s1_adv, w_s2_adv;

   assign w_s2_adv      = !r_s2_valid || out_ready;
   assign w_s1_adv      = !r_s1_valid || w_s2_adv;
   assign in_ready      = w_s1_adv;
   assign out_valid     = r_s2_valid;
   assign out_msg       = r_s2_msg;
   assign out_shift_err = r_s2_err;
   assign err_sticky    = r_sticky;
   assign beat_cnt      = r_cnt;

   // Rotation via a doubled copy of the lane vector: a plain right shift selects the wrapped window.
   for (genvar s = 0; s < S; s++) begin : g_s
      logic [SHIFT_W-1:0] w_f;
      assign w_f      = r_s1_shift[s*SHIFT_W +: SHIFT_W];
      assign w_err[s] = 32'(w_f) >= N;
      for (genvar q = 0; q < Q; q++) begin : g_q
         logic [N-1:0]   w_v;
         logic [2*N-1:0] w_dbl;
         assign w_v   = r_s1_msg[(s*Q+q)*N +: N];
         assign w_dbl = {w_v, w_v};
         assign w_rot[(s*Q+q)*N +: N] = w_err[s]    ? w_v :
                                        r_s1_dir[s] ? N'(w_dbl >> (N - 32'(w_f))) :
                                                      N'(w_dbl >> w_f);
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_msg   <= '0;
         r_s1_shift <= '0;
         r_s1_dir   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_msg   <= '0;
         r_s2_err   <= '0;
         r_sticky   <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (in_valid && w_s1_adv) begin
            r_s1_valid <= 1'b1;
            r_s1_msg   <= in_msg;
            r_s1_shift <= in_shift;
            r_s1_dir   <= in_dir;
         end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_msg   <= w_rot;
            r_s2_err   <= w_err;
         end
         // A clear wins over a handshake landing on the same edge.
         if (err_clr) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
         end else if (r_s2_valid && out_ready) begin
            r_cnt    <= r_cnt + 16'd1;
            r_sticky <= r_sticky || (|r_s2_err);
         end
      end
   end
endmodule

// File: tb/tb_column_l1route_pipe.sv
// tb_column_l1route_pipe: directed and random stimulus checked every cycle against a queue-based
// reference model that rotates lanes one step at a time.
module tb_column_l1route_pipe;
   localparam int Q = 4, N = 15, S = 3, SW = 4, MSG_W = S*Q*N;

   logic               sys_clk, rstn, in_valid, in_ready, out_valid, out_ready, err_sticky, err_clr;
   logic [MSG_W-1:0]   in_msg, out_msg;
   logic [S*SW-1:0]    in_shift;
   logic [S-1:0]       in_dir, out_shift_err;
   logic [15:0]        beat_cnt;

   typedef struct {
      logic [MSG_W-1:0] msg;
      logic [S-1:0]     err;
      int               stamp;
   } ent_t;

   ent_t        q[$];
   int          total = 0, passed = 0, cyc = 0;
   logic [15:0] m_cnt = '0;
   logic        m_st = 1'b0;

   column_l1route_pipe #(.QUAN_SIZE(Q), .STRIDE_UNIT_SIZE(N), .STRIDE_WIDTH(S)) dut (
      .sys_clk(sys_clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_msg(in_msg), .in_shift(in_shift), .in_dir(in_dir), .out_valid(out_valid),
      .out_ready(out_ready), .out_msg(out_msg), .out_shift_err(out_shift_err),
      .err_sticky(err_sticky), .err_clr(err_clr), .beat_cnt(beat_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic ent_t model(input logic [MSG_W-1:0] m, input logic [S*SW-1:0] sh,
                                  input logic [S-1:0] d);
      ent_t e;
      logic [N-1:0] v;
      int f;
      e.msg = m;
      e.err = '0;
      e.stamp = 0;
      for (int s = 0; s < S; s++) begin
         f = int'(sh[s*SW +: SW]);
         if (f >= N) e.err[s] = 1'b1;
         else for (int p = 0; p < Q; p++) begin
            v = m[(s*Q+p)*N +: N];
            for (int i = 0; i < f; i++) v = d[s] ? {v[N-2:0], v[N-1]} : {v[0], v[N-1:1]};
            e.msg[(s*Q+p)*N +: N] = v;
         end
      end
      return e;
   endfunction

   function automatic logic [MSG_W-1:0] rnd();
      logic [MSG_W-1:0] r;
      for (int i = 0; i < MSG_W; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   always @(negedge sys_clk) begin
      logic exp_v, hs;
      ent_t e;
      cyc++;
      exp_v = q.size() > 0 && (cyc - q[0].stamp >= 2);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, q.size() < 2 || out_ready);
      chk("beat_cnt", beat_cnt, m_cnt);
      chk("err_sticky", err_sticky, m_st);
      if (exp_v && out_valid) begin
         chk("out_msg", out_msg, q[0].msg);
         chk("out_shift_err", out_shift_err, q[0].err);
      end
      if (rstn) begin
         hs = exp_v && out_ready;
         if (err_clr) begin
            m_cnt = '0;
            m_st = 1'b0;
         end else if (hs) begin
            m_cnt = m_cnt + 16'd1;
            if (q[0].err != '0) m_st = 1'b1;
         end
         if (hs) void'(q.pop_front());
         if (in_valid && in_ready) begin
            e = model(in_msg, in_shift, in_dir);
            e.stamp = cyc;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [MSG_W-1:0] m, input logic [S*SW-1:0] sh, input logic [S-1:0] d);
      int n = 0;
      in_msg = m; in_shift = sh; in_dir = d; in_valid = 1'b1;
      @(negedge sys_clk);
      while (!in_ready) begin
         if (++n > 100) begin
            $display("FAIL send_timeout: in_ready stuck low");
            $fatal(1, "timeout");
         end
         @(negedge sys_clk);
      end
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      logic [MSG_W-1:0] m;
      ent_t e;
      sys_clk = 0; rstn = 0; in_valid = 0; out_ready = 1; err_clr = 0;
      in_msg = '0; in_shift = '0; in_dir = '0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_msg", out_msg, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge sys_clk); #1 rstn = 1;
      tick(1);

      // single beat: alternating pattern, shifts (1,0,14)
      m = '0;
      m[0 +: N]        = 15'h2AAA;
      m[(1*Q+2)*N +: N] = 15'h1234;
      m[(2*Q)*N +: N]   = 15'h0001;
      e = model(m, {4'd14, 4'd0, 4'd1}, 3'b000);
      chk("model_rot1", e.msg[0 +: N], 15'h1555);
      chk("model_rot14", e.msg[(2*Q)*N +: N], 15'h0002);
      send(m, {4'd14, 4'd0, 4'd1}, 3'b000);
      tick(1);
      chk("t1_valid", out_valid, 1);
      chk("t1_s0", out_msg[0 +: N], 15'h1555);
      chk("t1_s1", out_msg[(1*Q+2)*N +: N], 15'h1234);
      chk("t1_s2", out_msg[(2*Q)*N +: N], 15'h0002);
      chk("t1_err", out_shift_err, 3'b000);
      tick(1);
      chk("t1_cnt", beat_cnt, 1);

      // direction: one-hot lane 0 on every plane of stride1
      m = '0;
      for (int p = 0; p < Q; p++) m[(Q+p)*N] = 1'b1;
      e = model(m, {4'd0, 4'd3, 4'd0}, 3'b010);
      chk("model_dn3", e.msg[(Q+1)*N +: N], 15'h0008);
      e = model(m, {4'd0, 4'd3, 4'd0}, 3'b000);
      chk("model_up3", e.msg[(Q+3)*N +: N], 15'h1000);
      send(m, {4'd0, 4'd3, 4'd0}, 3'b010);
      tick(1);
      chk("dir1_lane3", out_msg[(Q+2)*N +: N], 15'h0008);
      send(m, {4'd0, 4'd3, 4'd0}, 3'b000);
      tick(1);
      chk("dir0_lane12", out_msg[(Q+2)*N +: N], 15'h1000);
      tick(1);
      chk("dir_cnt", beat_cnt, 3);

      // range error on stride2
      m = '0;
      m[(2*Q+1)*N +: N] = 15'h4321;
      send(m, {4'd15, 4'd0, 4'd0}, 3'b000);
      tick(1);
      chk("rng_err", out_shift_err, 3'b100);
      chk("rng_pass", out_msg[(2*Q+1)*N +: N], 15'h4321);
      tick(1);
      chk("rng_sticky", err_sticky, 1);
      err_clr = 1;
      tick(1);
      err_clr = 0;
      chk("clr_sticky", err_sticky, 0);
      chk("clr_cnt", beat_cnt, 0);

      // backpressure: 5 beats against a stalled sink
      out_ready = 0;
      fork
         for (int i = 0; i < 5; i++) send(rnd(), 12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)));
         begin
            repeat (2) @(posedge sys_clk);
            #2 chk("bp_in_ready_low", in_ready, 0);
            tick(4);
            out_ready = 1;
         end
      join
      tick(5);
      chk("bp_cnt", beat_cnt, 5);

      // sustained random stream
      for (int i = 0; i < 100; i++) send(rnd(), 12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)));
      tick(4);
      chk("tp_cnt", beat_cnt, 105);

      // reset with two beats in flight
      out_ready = 0;
      send(rnd(), {4'd1, 4'd2, 4'd3}, 3'b101);
      send(rnd(), {4'd4, 4'd5, 4'd6}, 3'b010);
      rstn = 0;
      q.delete();
      m_cnt = '0;
      m_st = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", beat_cnt, 0);
      tick(2);
      rstn = 1;
      out_ready = 1;
      tick(5);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_cnt", beat_cnt, 0);
      chk("drained", q.size() == 0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
